pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage ARMv8 (LEGv8) pipeline. It decides each cycle whether the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers advance, hold, bubble or flush. It drives the ALU operand forwarding selects and freezes the pipeline while a data-memory access in MEM is waiting. It sits beside the pipeline registers, reading their register-number and control fields, and also keeps stall and flush performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent in MEM_WAIT before forced release.
- CNT_W, 32: width of the performance counters.

Ports:
- CLOCK  in  1  the single clock; all state updates on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- id_rn, id_rm  in  5 each  source registers of the instruction in ID.
- id_uses_rn, id_uses_rm  in  1 each  ID instruction actually reads that source.
- idex_rn, idex_rm  in  5 each  source registers of the instruction in EX.
- idex_memRead, idex_regWrite  in  1 each  ID/EX control fields.
- idex_writeReg  in  5  ID/EX destination.
- exmem_isBranch, exmem_ALUzero, exmem_memRead, exmem_memWrite, exmem_regWrite  in  1 each  EX/MEM control fields.
- exmem_writeReg  in  5  EX/MEM destination.
- memwb_regWrite  in  1  MEM/WB write enable.
- memwb_writeReg  in  5  MEM/WB destination.
- dmem_ready  in  1  data memory has completed the current access this cycle.
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register load enables.
- idex_bubble  out  1  load zeroed control into ID/EX.
- memwb_bubble  out  1  load zeroed control into MEM/WB.
- ifid_flush, idex_flush, exmem_flush  out  1 each  zero control fields of that register.
- pc_src  out  1  select the branch target (the shifted PC from EX/MEM).
- forward_a, forward_b  out  2 each  ALU operand select: 00 register file, 10 EX/MEM ALU result, 01 MEM/WB write-back data.
- mem_fault  out  1  sticky flag: a memory access timed out.
- stall_count, flush_count  out  CNT_W each  performance counters.

## Operation
- Register X31 (XZR) never creates a hazard and is never forwarded.
- FSM states are RUN and MEM_WAIT.
- Freeze condition:
  - In RUN: (exmem_memRead | exmem_memWrite) & !dmem_ready.
  - In MEM_WAIT: !dmem_ready and timeout not yet reached.
  - While frozen: pc_write, ifid_write, idex_write and exmem_write are 0, and memwb_bubble is 1.
- RUN to MEM_WAIT when the freeze condition is true. MEM_WAIT to RUN on dmem_ready=1; freeze drops in that same cycle.
- Timeout counter:
  - Cleared on entering MEM_WAIT; increments each MEM_WAIT cycle.
  - When it equals MEM_TIMEOUT-1 and dmem_ready=0: set mem_fault, drop freeze that cycle, return to RUN.
  - mem_fault is cleared only by reset.
- Branch taken: exmem_isBranch & exmem_ALUzero. Effects:
  - pc_src=1.
  - ifid_flush, idex_flush and exmem_flush are all 1.
  - The PC and all registers load normally.
- Load-use: idex_memRead & idex_regWrite & idex_writeReg!=31 & ((id_uses_rn & id_rn==idex_writeReg) | (id_uses_rm & id_rm==idex_writeReg)). Effects:
  - pc_write=0 and ifid_write=0.
  - idex_bubble=1.
  - Exactly one cycle per occurrence.
- Priority: freeze > branch taken > load-use. The lower-priority action is fully suppressed.
- Forwarding for operand A (B is identical, using idex_rm):
  - Select 10 if exmem_regWrite & !exmem_memRead & exmem_writeReg!=31 & exmem_writeReg==idex_rn.
  - Otherwise 01 if memwb_regWrite & memwb_writeReg!=31 & memwb_writeReg==idex_rn.
  - Otherwise 00.
  - Forwarding is evaluated during a freeze too; it is harmless because the registers hold.
- Counters:
  - stall_count increments in every cycle with pc_write=0 and no branch-taken flush.
  - flush_count increments once per taken branch.
  - Both saturate at all-ones.

## Timing
- All control outputs are combinational from the inputs and the registered state: the same-cycle decision takes effect at the next CLOCK edge.
- Registered elements: FSM state, timeout counter, mem_fault, stall_count, flush_count.
- Reset (RESET_N low, asynchronous) sets state=RUN, timeout counter=0, mem_fault=0, counters=0. With idle inputs this yields pc_write, ifid_write, idex_write, exmem_write = 1 and every other output 0.
- Reset asserted mid-MEM_WAIT aborts the wait immediately; freeze drops with no edge required.
- Load-use costs exactly 1 stall cycle.
- A taken branch costs 3 flushed slots and no stall.
- A memory access costs N stall cycles, where N is the number of cycles dmem_ready stays low, capped at MEM_TIMEOUT.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - State encoding: RUN=1'b0, MEM_WAIT=1'b1.
  - FWD_REG=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10.
  - XZR=5'd31.
- One combinational sub-module, forwarding_unit, produces forward_a and forward_b.
- The FSM, hazard priority logic and counters live in the top module.

## Test plan
- Load-use: LDUR X2 in EX; ADD reading X2 in ID (id_rn=2, id_uses_rn=1) -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_count=1.
- Load-use on XZR: idex_writeReg=31, id_rn=31 -> no stall; pc_write=1.
- Forwarding: exmem_writeReg=5 and memwb_writeReg=5, both regWrite=1, idex_rn=5 -> forward_a=10. Then set exmem_memRead=1 -> forward_a=01.
- Branch: exmem_isBranch=1, exmem_ALUzero=1 together with a load-use condition -> pc_src=1, all three flushes=1, idex_bubble=0; flush_count=1, stall_count unchanged.
- Memory wait: exmem_memRead=1 with dmem_ready low for 3 cycles -> freeze and memwb_bubble for 3 cycles, released in the dmem_ready cycle; stall_count=3. Repeat with MEM_TIMEOUT=4 and dmem_ready held low -> release after 4 cycles and mem_fault=1.
- Reset: drop RESET_N during MEM_WAIT -> outputs return to their idle values immediately; mem_fault=0 and counters=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the LEGv8 pipeline hazard controller: FSM states,
// forwarding selects, the zero register and the forwarding select rule.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [4:0] XZR = 5'd31;

    // EX/MEM has the newer value, so it wins over MEM/WB; XZR is never a source.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic       exmem_en,
        input logic [4:0] exmem_rd,
        input logic       memwb_en,
        input logic [4:0] memwb_rd
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != XZR) begin
            if (exmem_en && exmem_rd == src) begin
                sel = FWD_EXMEM;
            end else if (memwb_en && memwb_rd == src) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// ALU operand forwarding selects for the instruction currently in EX.
module forwarding_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] idex_rn_i,
    input  logic [4:0] idex_rm_i,
    input  logic       exmem_regwrite_i,
    input  logic       exmem_memread_i,
    input  logic [4:0] exmem_writereg_i,
    input  logic       memwb_regwrite_i,
    input  logic [4:0] memwb_writereg_i,
    output logic [1:0] forward_a_o,
    output logic [1:0] forward_b_o
);

    logic exmem_fwd_en;

    // A load result is not available in EX/MEM yet, only its address.
    assign exmem_fwd_en = exmem_regwrite_i & ~exmem_memread_i;

    assign forward_a_o = fwd_select(idex_rn_i, exmem_fwd_en, exmem_writereg_i,
                                    memwb_regwrite_i, memwb_writereg_i);
    assign forward_b_o = fwd_select(idex_rm_i, exmem_fwd_en, exmem_writereg_i,
                                    memwb_regwrite_i, memwb_writereg_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage LEGv8 pipeline: memory-wait
// freeze FSM, branch flush, load-use stall, forwarding and perf counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [4:0]       idex_rn,
    input  logic [4:0]       idex_rm,
    input  logic             idex_memRead,
    input  logic             idex_regWrite,
    input  logic [4:0]       idex_writeReg,
    input  logic             exmem_isBranch,
    input  logic             exmem_ALUzero,
    input  logic             exmem_memRead,
    input  logic             exmem_memWrite,
    input  logic             exmem_regWrite,
    input  logic [4:0]       exmem_writeReg,
    input  logic             memwb_regWrite,
    input  logic [4:0]       memwb_writeReg,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pc_src,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int             TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic mem_access;
    logic branch_taken;
    logic load_use_raw;
    logic load_use;

    assign mem_access = exmem_memRead | exmem_memWrite;

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        fault_d  = fault_q;
        freeze   = 1'b0;
        if (state_q == RUN) begin
            if (mem_access && !dmem_ready) begin
                freeze   = 1'b1;
                state_d  = MEM_WAIT;
                to_cnt_d = '0;
            end
        end else begin
            if (dmem_ready) begin
                state_d = RUN;
            end else if (to_cnt_q == TO_LAST) begin
                // Give up on the access: release the pipeline and flag it.
                fault_d = 1'b1;
                state_d = RUN;
            end else begin
                freeze   = 1'b1;
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    assign load_use_raw = idex_memRead & idex_regWrite & (idex_writeReg != XZR) &
                          ((id_uses_rn & (id_rn == idex_writeReg)) |
                           (id_uses_rm & (id_rm == idex_writeReg)));

    // Priority: freeze, then taken branch, then load-use.
    assign branch_taken = ~freeze & exmem_isBranch & exmem_ALUzero;
    assign load_use     = ~freeze & ~branch_taken & load_use_raw;

    assign pc_write     = ~freeze & ~load_use;
    assign ifid_write   = ~freeze & ~load_use;
    assign idex_write   = ~freeze;
    assign exmem_write  = ~freeze;
    assign idex_bubble  = load_use;
    assign memwb_bubble = freeze;
    assign pc_src       = branch_taken;
    assign ifid_flush   = branch_taken;
    assign idex_flush   = branch_taken;
    assign exmem_flush  = branch_taken;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && !branch_taken && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_taken && flush_cnt_q != {CNT_W{1'b1}}) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= RUN;
            to_cnt_q    <= '0;
            fault_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            fault_q     <= fault_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_fault   = fault_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

    forwarding_unit u_fwd (
        .idex_rn_i        (idex_rn),
        .idex_rm_i        (idex_rm),
        .exmem_regwrite_i (exmem_regWrite),
        .exmem_memread_i  (exmem_memRead),
        .exmem_writereg_i (exmem_writeReg),
        .memwb_regwrite_i (memwb_regWrite),
        .memwb_writereg_i (memwb_writeReg),
        .forward_a_o      (forward_a),
        .forward_b_o      (forward_b)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl against a cycle-level
// reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 4;

    logic       clk;
    logic       RESET_N;
    logic [4:0] id_rn, id_rm, idex_rn, idex_rm, idex_writeReg, exmem_writeReg, memwb_writeReg;
    logic       id_uses_rn, id_uses_rm, idex_memRead, idex_regWrite;
    logic       exmem_isBranch, exmem_ALUzero, exmem_memRead, exmem_memWrite, exmem_regWrite;
    logic       memwb_regWrite, dmem_ready;

    logic        pc_write, ifid_write, idex_write, exmem_write, idex_bubble, memwb_bubble;
    logic        ifid_flush, idex_flush, exmem_flush, pc_src, mem_fault;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] stall_count, flush_count;

    logic        s_pc_write, s_ifid_write, s_idex_write, s_exmem_write, s_idex_bubble, s_memwb_bubble;
    logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_pc_src, s_mem_fault;
    logic [1:0]  s_forward_a, s_forward_b;
    logic [3:0]  s_stall_count, s_flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: whether the previous cycle was frozen, how many
    // consecutive frozen cycles so far, sticky fault and raw event counts.
    bit m_waiting;
    int m_run;
    bit m_fault;
    int m_stall;
    int m_flush;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .CLOCK(clk), .RESET_N(RESET_N),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .idex_rn(idex_rn), .idex_rm(idex_rm), .idex_memRead(idex_memRead),
        .idex_regWrite(idex_regWrite), .idex_writeReg(idex_writeReg),
        .exmem_isBranch(exmem_isBranch), .exmem_ALUzero(exmem_ALUzero),
        .exmem_memRead(exmem_memRead), .exmem_memWrite(exmem_memWrite),
        .exmem_regWrite(exmem_regWrite), .exmem_writeReg(exmem_writeReg),
        .memwb_regWrite(memwb_regWrite), .memwb_writeReg(memwb_writeReg),
        .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .pc_src(pc_src), .forward_a(forward_a), .forward_b(forward_b),
        .mem_fault(mem_fault), .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut_sat (
        .CLOCK(clk), .RESET_N(RESET_N),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .idex_rn(idex_rn), .idex_rm(idex_rm), .idex_memRead(idex_memRead),
        .idex_regWrite(idex_regWrite), .idex_writeReg(idex_writeReg),
        .exmem_isBranch(exmem_isBranch), .exmem_ALUzero(exmem_ALUzero),
        .exmem_memRead(exmem_memRead), .exmem_memWrite(exmem_memWrite),
        .exmem_regWrite(exmem_regWrite), .exmem_writeReg(exmem_writeReg),
        .memwb_regWrite(memwb_regWrite), .memwb_writeReg(memwb_writeReg),
        .dmem_ready(dmem_ready),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idex_write(s_idex_write),
        .exmem_write(s_exmem_write), .idex_bubble(s_idex_bubble), .memwb_bubble(s_memwb_bubble),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
        .pc_src(s_pc_src), .forward_a(s_forward_a), .forward_b(s_forward_b),
        .mem_fault(s_mem_fault), .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] src);
        if (src != 5'd31 && exmem_regWrite && !exmem_memRead && exmem_writeReg == src) return 2'b10;
        if (src != 5'd31 && memwb_regWrite && memwb_writeReg == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic logic [4:0] rnd_reg();
        case ($urandom_range(0, 3))
            0: return 5'd1;
            1: return 5'd2;
            2: return 5'd3;
            default: return 5'd31;
        endcase
    endfunction

    task automatic model_reset();
        m_waiting = 0; m_run = 0; m_fault = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic idle();
        id_rn = 0; id_rm = 0; id_uses_rn = 0; id_uses_rm = 0;
        idex_rn = 0; idex_rm = 0; idex_memRead = 0; idex_regWrite = 0; idex_writeReg = 0;
        exmem_isBranch = 0; exmem_ALUzero = 0; exmem_memRead = 0; exmem_memWrite = 0;
        exmem_regWrite = 0; exmem_writeReg = 0; memwb_regWrite = 0; memwb_writeReg = 0;
        dmem_ready = 1;
    endtask

    // Compare everything at the falling edge, then advance the model one cycle.
    task automatic tick();
        bit want, frz, tmo, br, lu_raw, lu;
        @(negedge clk);
        want   = (m_waiting ? 1'b1 : (exmem_memRead | exmem_memWrite)) && !dmem_ready;
        frz    = want && (m_run < TO);
        tmo    = m_waiting && !dmem_ready && (m_run >= TO);
        br     = !frz && exmem_isBranch && exmem_ALUzero;
        lu_raw = idex_memRead && idex_regWrite && idex_writeReg != 5'd31 &&
                 ((id_uses_rn && id_rn == idex_writeReg) || (id_uses_rm && id_rm == idex_writeReg));
        lu     = !frz && !br && lu_raw;
        check("pc_write",     32'(pc_write),     32'(!(frz || lu)));
        check("ifid_write",   32'(ifid_write),   32'(!(frz || lu)));
        check("idex_write",   32'(idex_write),   32'(!frz));
        check("exmem_write",  32'(exmem_write),  32'(!frz));
        check("idex_bubble",  32'(idex_bubble),  32'(lu));
        check("memwb_bubble", 32'(memwb_bubble), 32'(frz));
        check("pc_src",       32'(pc_src),       32'(br));
        check("flushes",      {29'd0, ifid_flush, idex_flush, exmem_flush}, br ? 32'd7 : 32'd0);
        check("forward_a",    32'(forward_a),    32'(fwd_ref(idex_rn)));
        check("forward_b",    32'(forward_b),    32'(fwd_ref(idex_rm)));
        check("mem_fault",    32'(mem_fault),    32'(m_fault));
        check("stall_count",  stall_count,       32'(m_stall));
        check("flush_count",  flush_count,       32'(m_flush));
        check("sat_stall",    32'(s_stall_count), 32'(sat15(m_stall)));
        check("sat_flush",    32'(s_flush_count), 32'(sat15(m_flush)));
        check("sat_fault",    32'(s_mem_fault),   32'(m_fault));
        if (frz) begin m_waiting = 1; m_run++; end
        else     begin m_waiting = 0; m_run = 0; end
        if (tmo) m_fault = 1;
        if (!(frz || lu)) begin end else m_stall++;
        if (br) m_flush++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        RESET_N = 1'b0;
        #3;
        check("rst_pc_write",     32'(pc_write),     32'd1);
        check("rst_exmem_write",  32'(exmem_write),  32'd1);
        check("rst_memwb_bubble", 32'(memwb_bubble), 32'd0);
        check("rst_mem_fault",    32'(mem_fault),    32'd0);
        check("rst_stall_count",  stall_count,       32'd0);
        check("rst_flush_count",  flush_count,       32'd0);
        @(negedge clk);
        RESET_N = 1'b1;
        @(posedge clk);
        #1;
        tick();

        // Load-use: LDUR X2 in EX, consumer of X2 in ID.
        idex_memRead = 1; idex_regWrite = 1; idex_writeReg = 5'd2; id_rn = 5'd2; id_uses_rn = 1;
        tick();
        idle();
        tick();
        check("lu_stall_count", stall_count, 32'd1);

        // Load-use on XZR never stalls.
        idex_memRead = 1; idex_regWrite = 1; idex_writeReg = 5'd31; id_rn = 5'd31; id_uses_rn = 1;
        #1;
        check("xzr_pc_write", 32'(pc_write), 32'd1);
        tick();
        idle();

        // Forwarding priority, then EX/MEM holds a load.
        exmem_regWrite = 1; exmem_writeReg = 5'd5; memwb_regWrite = 1; memwb_writeReg = 5'd5;
        idex_rn = 5'd5; idex_rm = 5'd5;
        #1;
        check("fwd_exmem", 32'(forward_a), 32'd2);
        tick();
        exmem_memRead = 1;
        #1;
        check("fwd_memwb", 32'(forward_a), 32'd1);
        tick();
        idle();

        // Taken branch suppresses a simultaneous load-use.
        exmem_isBranch = 1; exmem_ALUzero = 1;
        idex_memRead = 1; idex_regWrite = 1; idex_writeReg = 5'd2; id_rm = 5'd2; id_uses_rm = 1;
        tick();
        idle();
        check("br_flush_count", flush_count, 32'd1);
        check("br_stall_count", stall_count, 32'd1);

        // Memory wait of three cycles.
        exmem_memRead = 1; dmem_ready = 0;
        repeat (3) tick();
        dmem_ready = 1;
        #1;
        check("mw_release", 32'(pc_write), 32'd1);
        tick();
        idle();
        check("mw_stall_count", stall_count, 32'd4);

        // Timeout with dmem_ready held low.
        exmem_memRead = 1; dmem_ready = 0;
        repeat (5) tick();
        idle();
        check("to_mem_fault",   32'(mem_fault), 32'd1);
        check("to_stall_count", stall_count,    32'd8);
        tick();

        // Randomized traffic, with stretches of a slow memory.
        for (int i = 0; i < 400; i++) begin
            id_rn = rnd_reg(); id_rm = rnd_reg();
            id_uses_rn = 1'($urandom_range(0, 1)); id_uses_rm = 1'($urandom_range(0, 1));
            idex_rn = rnd_reg(); idex_rm = rnd_reg(); idex_writeReg = rnd_reg();
            idex_memRead = 1'($urandom_range(0, 1)); idex_regWrite = 1'($urandom_range(0, 1));
            exmem_isBranch = ($urandom_range(0, 3) == 0); exmem_ALUzero = 1'($urandom_range(0, 1));
            exmem_memRead = ($urandom_range(0, 3) == 0); exmem_memWrite = ($urandom_range(0, 5) == 0);
            exmem_regWrite = 1'($urandom_range(0, 1)); exmem_writeReg = rnd_reg();
            memwb_regWrite = 1'($urandom_range(0, 1)); memwb_writeReg = rnd_reg();
            dmem_ready = ($urandom_range(0, 7) < (((i / 40) % 2 == 1) ? 1 : 6));
            tick();
        end

        // Reset in the middle of a memory wait.
        idle();
        exmem_memRead = 1; dmem_ready = 0;
        tick();
        tick();
        exmem_memRead = 0;
        #2;
        check("wait_hold_pc_write", 32'(pc_write), 32'd0);
        RESET_N = 1'b0;
        #1;
        check("arst_pc_write",     32'(pc_write),     32'd1);
        check("arst_idex_write",   32'(idex_write),   32'd1);
        check("arst_memwb_bubble", 32'(memwb_bubble), 32'd0);
        check("arst_mem_fault",    32'(mem_fault),    32'd0);
        check("arst_stall_count",  stall_count,       32'd0);
        check("arst_flush_count",  flush_count,       32'd0);
        model_reset();
        idle();
        @(negedge clk);
        RESET_N = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
